// File: rtl/seg_display_arbiter_if.sv
// Handshake bundle between the digit requesters and the seven-segment arbiter.
// master = requester side (drives req/digit), slave = arbiter side (drives grant/display).
interface seg_display_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int OWNER_W = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]   req;
   logic [3*NUM_REQ-1:0] digit;
   logic [NUM_REQ-1:0]   gnt;
   logic [OWNER_W-1:0]   owner;
   logic                 busy;
   logic [6:0]           seg;

   modport master (output req, digit, input gnt, owner, busy, seg);
   modport slave  (input req, digit, output gnt, owner, busy, seg);
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of a single active-low 7-segment display; each owner holds it
// for up to HOLD_CYCLES cycles, with one blank cycle between different owners.
module seg_display_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 20000000,
   parameter int OWNER_W     = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   seg_display_arbiter_if.slave   bus
);
   localparam int                 CNT_W     = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [6:0]         SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HOLD = 2'b01,
      GAP  = 2'b10
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [OWNER_W-1:0]   owner_q, owner_d;
   logic                 busy_q, busy_d;
   logic [6:0]           seg_q, seg_d;
   logic [OWNER_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;

   logic                 win_found_s;
   logic [OWNER_W-1:0]   win_idx_s;
   logic                 owner_req_s;
   logic                 others_pend_s;

   function automatic logic [6:0] encode(input logic [2:0] d);
      logic [6:0] s;
      case (d)
         3'd0:    s = 7'b0000001;
         3'd1:    s = 7'b1001111;
         3'd2:    s = 7'b0010010;
         3'd3:    s = 7'b0000110;
         3'd4:    s = 7'b1001100;
         3'd5:    s = 7'b0100100;
         3'd6:    s = 7'b0100000;
         3'd7:    s = 7'b0001111;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   function automatic logic [2:0] digit_of(input logic [3*NUM_REQ-1:0] dig,
                                           input logic [OWNER_W-1:0]   sel);
      logic [2:0] d;
      d = 3'b000;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel == OWNER_W'(i)) begin
            d = dig[3*i +: 3];
         end else begin
            d = d;
         end
      end
      return d;
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input logic [OWNER_W-1:0] sel);
      logic [NUM_REQ-1:0] oh;
      oh = '0;
      oh[sel] = 1'b1;
      return oh;
   endfunction

   function automatic logic [OWNER_W-1:0] next_ptr(input logic [OWNER_W-1:0] cur);
      logic [OWNER_W-1:0] n;
      if (cur == OWNER_W'(NUM_REQ - 1)) begin
         n = '0;
      end else begin
         n = cur + OWNER_W'(1);
      end
      return n;
   endfunction

   // Search order rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; returns {found, index}.
   function automatic logic [OWNER_W:0] pick(input logic [NUM_REQ-1:0] r,
                                             input logic [OWNER_W-1:0] ptr);
      logic               found;
      logic [OWNER_W-1:0] win;
      logic [OWNER_W-1:0] sel;
      int                 idx;
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end else begin
            idx = idx;
         end
         sel = idx[OWNER_W-1:0];
         if (!found && r[sel]) begin
            found = 1'b1;
            win   = sel;
         end else begin
            found = found;
         end
      end
      return {found, win};
   endfunction

   assign {win_found_s, win_idx_s} = pick(bus.req, rr_ptr_q);
   assign owner_req_s   = bus.req[owner_q];
   assign others_pend_s = |(bus.req & ~onehot(owner_q));

   // Next-state and registered-output computation.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      owner_d    = owner_q;
      busy_d     = busy_q;
      seg_d      = seg_q;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         IDLE, GAP: begin
            if (win_found_s) begin
               state_d    = HOLD;
               gnt_d      = onehot(win_idx_s);
               owner_d    = win_idx_s;
               busy_d     = 1'b1;
               hold_cnt_d = '0;
               seg_d      = encode(digit_of(bus.digit, win_idx_s));
            end else begin
               state_d    = IDLE;
               gnt_d      = '0;
               busy_d     = 1'b0;
               hold_cnt_d = '0;
               seg_d      = SEG_BLANK;
            end
         end
         HOLD: begin
            // Release on drop, or on expiry when someone else is waiting.
            if (!owner_req_s || ((hold_cnt_q == HOLD_LAST) && others_pend_s)) begin
               state_d    = GAP;
               gnt_d      = '0;
               busy_d     = 1'b0;
               hold_cnt_d = '0;
               seg_d      = SEG_BLANK;
               rr_ptr_d   = next_ptr(owner_q);
            end else if (hold_cnt_q == HOLD_LAST) begin
               hold_cnt_d = '0;
               seg_d      = encode(digit_of(bus.digit, owner_q));
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
               seg_d      = encode(digit_of(bus.digit, owner_q));
            end
         end
         default: begin
            state_d    = IDLE;
            gnt_d      = '0;
            busy_d     = 1'b0;
            hold_cnt_d = '0;
            seg_d      = SEG_BLANK;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         owner_q    <= '0;
         busy_q     <= 1'b0;
         seg_q      <= SEG_BLANK;
         rr_ptr_q   <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         owner_q    <= owner_d;
         busy_q     <= busy_d;
         seg_q      <= seg_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.owner = owner_q;
   assign bus.busy  = busy_q;
   assign bus.seg   = seg_q;
endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Round-robin arbiter that time-shares one 7-segment display among NUM_REQ requesters.
- Typical requesters are FSM state indicators on the Vaman board.
- Each granted requester owns the display for up to HOLD_CYCLES clk cycles. Its 3-bit digit is shown in active-low {a..g} encoding.
- Sits between the per-FSM digit sources and the board's single seven-segment pin group.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 20000000, maximum cycles one owner holds the display (>=1).
- OWNER_W, $clog2(NUM_REQ), width of owner index.

Ports:
- clk  input  1  system clock (Sys_Clk0 domain).
- rst  input  1  synchronous reset, active-high.
- req  input  NUM_REQ  request vector, bit i = requester i wants the display; level-held.
- digit  input  3*NUM_REQ  packed digit codes; requester i uses digit[3i+2:3i].
- gnt  output  NUM_REQ  one-hot grant, registered.
- owner  output  OWNER_W  index of current owner; valid while busy=1.
- busy  output  1  high while a requester holds the display.
- seg  output  7  {a,b,c,d,e,f,g}, active-low, registered.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values (next clk edge with rst=1, from any state): state=IDLE, gnt=0, owner=0, busy=0, seg=7'b1111111 (blank), rr_ptr=0, hold_cnt=0.
- States: IDLE, HOLD, GAP.
- IDLE:
  - If req==0, stay in IDLE with outputs blank.
  - Otherwise pick the first set req bit searching rr_ptr, rr_ptr+1, ... with wrap mod NUM_REQ.
  - Next edge: HOLD, gnt one-hot at the winner, owner=winner, busy=1, hold_cnt=0, seg=encode(digit[owner]).
  - Latency from req sampled to gnt visible: 1 cycle.
- HOLD:
  - Each cycle seg <= encode(digit of owner), sampled live, so a digit change appears 1 cycle later.
  - hold_cnt increments each cycle.
- HOLD, early release: if req[owner]==0, next edge go to GAP. gnt=0, busy=0, seg blank, rr_ptr=(owner+1) mod NUM_REQ.
- HOLD, expiry (hold_cnt==HOLD_CYCLES-1 with req[owner] still 1):
  - If any other req bit is set, go to GAP exactly as in early release.
  - If no other requester is pending, the owner is retained: hold_cnt=0, gnt/seg unchanged, no blank cycle.
- GAP:
  - Exactly one blank cycle.
  - Arbitration is the same as IDLE, from the updated rr_ptr.
  - If any req is set, next edge go to HOLD for the winner; otherwise go to IDLE.
  - The previous owner can win again only if no other requester is pending.
- Encode table (digit -> seg): 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111.
- Invariants:
  - gnt is always zero or one-hot, and gnt[owner]==busy.
  - seg is blank whenever busy=0.
- hold_cnt width: $clog2(HOLD_CYCLES+1). The counter never exceeds HOLD_CYCLES-1.
- Simultaneous requests in the same cycle are resolved by rr_ptr order only. Requests arriving during HOLD wait; no preemption.
- rst during HOLD or GAP aborts ownership at the next edge. rr_ptr returns to 0.

Test Plan (HOLD_CYCLES=4, NUM_REQ=4):
1. Reset: assert rst 2 cycles with req=4'b1111 -> gnt=0, busy=0, seg=7'b1111111. After release, first grant is gnt=4'b0001, owner=0, one cycle after rst falls.
2. Rotation: req=4'b1111 held, digit0..3 = 0,1,2,3. Required:
   - Owners cycle 0,1,2,3,0.
   - Each owner holds 4 cycles, followed by 1 blank GAP cycle.
   - seg shows 0000001, 1001111, 0010010, 0000110 in turn.
3. Sole requester: req=4'b0100, digit2=5 -> gnt=4'b0100 continuously across expiries, seg=0100100 with no blank cycles. Raise req[0] mid-hold -> at the next expiry, GAP then owner=0.
4. Early release: owner 1 drops req after 2 HOLD cycles with req[3] set -> next edge GAP (blank, gnt=0), then owner=3. rr_ptr skips 2 because req[2]=0.
5. Live digit: owner 0 changes digit 2->7 mid-hold -> seg goes 0010010 to 0001111 one cycle later, gnt unchanged.
6. Reset mid-hold: rst=1 on the 2nd HOLD cycle of owner 2 -> next edge gnt=0, seg blank. With req=4'b1111 afterwards, the next owner is 0.
